// File: rtl/pwm_gen.sv
// Counter/compare PWM generator with double-buffered period/duty and a load handshake.
// Optional center-aligned (up/down) counting is enabled by defining PWM_CENTER_ALIGNED_EN.
module pwm_gen #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEFAULT_PERIOD = 255
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             load,
  output logic             load_ack,
  output logic             pwm_d,
  output logic [WIDTH-1:0] cnt,
  output logic             period_end
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] period_act;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] period_sh;
  logic [WIDTH-1:0] duty_sh;
  logic             pending;
  logic             apply;
  logic [WIDTH-1:0] wrap_cnt;
  logic [WIDTH-1:0] cnt_next;
`ifdef PWM_CENTER_ALIGNED_EN
  logic             dir;       // 0 = up, 1 = down
  logic             dir_next;
  logic             wrap_dir;
`endif

  // State register
  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, counter successor, shadow-apply and terminal detection
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wrap_cnt   = '0;
    apply      = 1'b0;
    period_end = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_next = dir;
    wrap_dir = dir;
    if (!dir) begin
      if (cnt >= period_act) begin
        if (period_act > WIDTH'(1)) begin
          wrap_cnt = period_act - WIDTH'(1);
          wrap_dir = 1'b1;
        end
      end else begin
        wrap_cnt = cnt + WIDTH'(1);
      end
    end else if (cnt > WIDTH'(1)) begin
      wrap_cnt = cnt - WIDTH'(1);
    end else begin
      wrap_dir = 1'b0;
    end
`else
    wrap_cnt = (cnt >= period_act) ? '0 : cnt + WIDTH'(1);
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        apply    = pending;
`ifdef PWM_CENTER_ALIGNED_EN
        dir_next = 1'b0;
`endif
        if (en) state_next = RUN;
      end
      RUN: begin
        period_end = (wrap_cnt == '0);
        apply      = pending && period_end;
        if (en) begin
          cnt_next = wrap_cnt;
`ifdef PWM_CENTER_ALIGNED_EN
          dir_next = wrap_dir;
`endif
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
`ifdef PWM_CENTER_ALIGNED_EN
          dir_next   = 1'b0;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: counter, active/shadow registers, compare and ack
  always_ff @(posedge ck) begin
    if (rst) begin
      cnt        <= '0;
      period_act <= WIDTH'(DEFAULT_PERIOD);
      duty_act   <= '0;
      period_sh  <= '0;
      duty_sh    <= '0;
      pending    <= 1'b0;
      pwm_d      <= 1'b0;
      load_ack   <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir        <= 1'b0;
`endif
    end else begin
      cnt      <= cnt_next;
      load_ack <= load;
      pwm_d    <= (state == RUN) && en && (cnt < duty_act);
`ifdef PWM_CENTER_ALIGNED_EN
      dir      <= dir_next;
`endif
      if (apply) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
      end
      // A load coinciding with an apply keeps pending set for the next boundary
      if (load) begin
        period_sh <= period_in;
        duty_sh   <= duty_in;
        pending   <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Randomized and directed bench for pwm_gen against a phase-based reference model.
// Define PWM_CENTER_ALIGNED_EN for both bench and RTL to exercise center-aligned mode.
module tb_pwm_gen;

  localparam int unsigned WIDTH = 8;

  logic             ck = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] period_in;
  logic [WIDTH-1:0] duty_in;
  logic             load;
  logic             load_ack;
  logic             pwm_d;
  logic [WIDTH-1:0] cnt;
  logic             period_end;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position in period as a phase index, not a counter register
  bit m_run;
  int m_p;
  int m_per, m_duty, m_sh_per, m_sh_duty;
  bit m_pend, m_ack, m_pwm;

  pwm_gen #(.WIDTH(WIDTH), .DEFAULT_PERIOD(255)) dut (
    .ck(ck), .rst(rst), .en(en), .period_in(period_in), .duty_in(duty_in),
    .load(load), .load_ack(load_ack), .pwm_d(pwm_d), .cnt(cnt),
    .period_end(period_end)
  );

  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of(input int per);
`ifdef PWM_CENTER_ALIGNED_EN
    return (per == 0) ? 1 : 2 * per;
`else
    return per + 1;
`endif
  endfunction

  function automatic int cnt_of(input int p, input int per);
`ifdef PWM_CENTER_ALIGNED_EN
    return (p <= per) ? p : 2 * per - p;
`else
    return p;
`endif
  endfunction

  function automatic int model_cnt();
    return m_run ? cnt_of(m_p, m_per) : 0;
  endfunction

  function automatic bit model_pe();
    return m_run && (m_p == len_of(m_per) - 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_p = 0; m_per = 255; m_duty = 0;
    m_sh_per = 0; m_sh_duty = 0; m_pend = 0; m_ack = 0; m_pwm = 0;
  endtask

  // One clock: drive, check at negedge, advance model at the rising edge
  task automatic step(input bit r, input bit e, input bit l, input int p, input int d);
    int  c;
    bit  pe, apply;
    bit  n_run, n_pend, n_ack, n_pwm;
    int  n_p, n_per, n_duty, n_sh_per, n_sh_duty;
    rst = r; en = e; load = l;
    period_in = WIDTH'(p); duty_in = WIDTH'(d);
    @(negedge ck);
    c  = model_cnt();
    pe = model_pe();
    check_eq("cnt", 32'(cnt), 32'(c));
    check_eq("period_end", 32'(period_end), 32'(pe));
    check_eq("pwm_d", 32'(pwm_d), 32'(m_pwm));
    check_eq("load_ack", 32'(load_ack), 32'(m_ack));
    apply     = m_pend && (!m_run || pe);
    n_ack     = l;
    n_pwm     = m_run && e && (c < m_duty);
    n_per     = apply ? m_sh_per : m_per;
    n_duty    = apply ? m_sh_duty : m_duty;
    n_sh_per  = l ? p : m_sh_per;
    n_sh_duty = l ? d : m_sh_duty;
    n_pend    = l ? 1'b1 : (apply ? 1'b0 : m_pend);
    n_p       = (m_run && e) ? ((m_p == len_of(m_per) - 1) ? 0 : m_p + 1) : 0;
    n_run     = e;
    @(posedge ck);
    #1;
    if (r) begin
      model_reset();
    end else begin
      m_run = n_run; m_p = n_p; m_per = n_per; m_duty = n_duty;
      m_sh_per = n_sh_per; m_sh_duty = n_sh_duty; m_pend = n_pend;
      m_ack = n_ack; m_pwm = n_pwm;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  // Run (en=1) until the model counter reaches target; bounded
  task automatic run_to_cnt(input int target, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_run && model_cnt() == target) hit = 1;
      else step(0, 1, 0, 0, 0);
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    // Reset held two cycles with en and load active
    rst = 1; en = 1; load = 1; period_in = 8'd5; duty_in = 8'd2;
    @(posedge ck);
    #1;
    model_reset();
    step(1, 1, 1, 5, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // Default period 255 after reset: no duty, but period_end after 256 cycles
    step(0, 1, 0, 0, 0);
    run_cycles(260);

    // Load period 9 / duty 3 while idle, then run
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 9, 3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    run_cycles(25);

    // Mid-period duty update at cnt=4
    run_to_cnt(4, "reach_cnt4");
    step(0, 1, 1, 9, 7);
    run_cycles(30);

    // Duty extremes
    step(0, 1, 1, 9, 0);
    run_cycles(25);
    step(0, 1, 1, 9, 10);
    run_cycles(25);
    step(0, 1, 1, 0, 1);
    run_cycles(15);

    // Enable drop with pending, then resume
    step(0, 1, 1, 6, 2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    run_cycles(20);

    // Reset mid-operation at cnt=5 with a pending load
    step(0, 1, 1, 9, 3);
    run_cycles(12);
    run_to_cnt(2, "reach_cnt2");
    step(0, 1, 1, 9, 5);
    run_to_cnt(5, "reach_cnt5");
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    run_cycles(5);

    // Center-aligned reference pattern (edge-aligned gives period 5)
    step(0, 0, 1, 4, 2);
    step(0, 0, 0, 0, 0);
    run_cycles(24);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l;
      int p, d;
      r = ($urandom_range(0, 399) == 0);
      e = ($urandom_range(0, 19) != 0);
      l = ($urandom_range(0, 14) == 0);
      p = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 14);
      step(r, e, l, p, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Counter/compare PWM generator that produces the raw PWM bit `pwm_d`.
- `pwm_d` feeds the single-bit output register stage of the PWM path (the `d` input of the downstream D flip-flop clocked by `ck`).
- Period and duty are double-buffered: host updates take effect only at a period boundary, so no glitched or truncated pulses.

Parameters:
WIDTH, 8, bit width of counter, period and duty
DEFAULT_PERIOD, 255, active period value after reset (counter terminal value)

Ports:
ck  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  run enable
period_in  input  WIDTH  requested period (terminal count)
duty_in  input  WIDTH  requested duty (high count)
load  input  1  one-cycle strobe capturing period_in/duty_in
load_ack  output  1  one-cycle pulse acknowledging a load
pwm_d  output  1  registered PWM bit to the output flip-flop
cnt  output  WIDTH  current counter value
period_end  output  1  high during the last cycle of each period

Behaviour:
- Interface: one clock `ck`; reset `rst` is synchronous and active-high.
- Reset values: cnt=0, period_act=DEFAULT_PERIOD, duty_act=0, pending=0, pwm_d=0, load_ack=0, period_end=0, state=IDLE, dir=UP.
- Load handshake:
  - `load`=1 at an edge copies period_in/duty_in into shadow registers and sets pending.
  - load_ack=1 in the following cycle only.
  - A load while pending is already set overwrites the shadow values and is still acked.
  - `load` is sampled every cycle; back-to-back loads produce back-to-back acks.
- States:
  - IDLE (en=0): cnt held at 0, pwm_d=0, period_end=0. Pending values are copied to active one cycle after capture, then pending clears.
  - RUN (en=1): counting.
  - IDLE->RUN when en=1; the first RUN cycle has cnt=0.
  - RUN->IDLE when en=0: cnt forced to 0 at the next edge; pending is kept.
- Edge-aligned counting (default): cnt goes 0,1,...,period_act,0,...; one period is period_act+1 cycles.
- Terminal cycle: period_end=1 (combinational from registered state) in the cycle where the next cnt is 0.
  - At that edge, if pending: period_act/duty_act <= shadow and pending clears.
  - If a load and a terminal edge coincide, the new values are captured to shadow and applied at the next boundary.
- Compare: pwm_d <= en && (cnt < duty_act), registered, so pwm_d lags cnt by 1 cycle.
  - duty_act=0: constant 0.
  - duty_act > period_act: constant 1 while running.
- period_act=0: cnt stays 0, period_end=1 every RUN cycle, pwm_d=1 iff duty_act>=1.
- Arithmetic: unsigned WIDTH-bit only; the compare is unsigned; no overflow possible because cnt never exceeds period_act.
- Reset mid-operation: all state returns to reset values at that edge; a captured-but-unapplied load is discarded and its ack is suppressed.

Optional Feature:
- Macro PWM_CENTER_ALIGNED_EN.
- Defined (center-aligned mode):
  - Adds a direction flag. cnt runs 0 up to period_act, then period_act-1 down to 1, then back to 0.
  - Period = 2*period_act cycles, with period_act=0 behaving as above.
  - Compare, period_end rule ("next cnt is 0") and shadow update are unchanged.
  - dir resets to UP, and is forced to UP on entering IDLE.
- Undefined: edge-aligned only; no direction logic is synthesized.

Test Plan:
- Reset: rst=1 for 2 cycles, with en=1 and load=1 driven -> cnt=0, pwm_d=0, load_ack=0, period_end=0; active period=255 on release.
- Load and run:
  - With en=0, load period=9, duty=3 -> load_ack=1 the next cycle.
  - Then en=1 -> period_end every 10 cycles; pwm_d high for 3 consecutive cycles per period, rising 1 cycle after cnt=0.
- Mid-period update: during the period=9/duty=3 run, load duty=7 at cnt=4 -> the current period keeps 3 high cycles; the next period has 7 high; pending clears at the cnt=9 edge.
- Duty extremes:
  - duty=0 -> pwm_d constant 0.
  - period=9, duty=10 -> pwm_d constant 1.
  - period=0, duty=1 -> cnt=0, period_end=1 every cycle, pwm_d=1.
- Reset mid-operation: rst=1 at cnt=5 while pending -> next cycle cnt=0, period_act=255, duty_act=0, pending=0, no load_ack.
- PWM_CENTER_ALIGNED_EN defined, period=4, duty=2 -> cnt sequence 0,1,2,3,4,3,2,1 repeating; period_end at cnt=1 descending; pwm_d high 3 of 8 cycles.
